mem_wb_stage: RTL
=================

// Module: mem_wb_stage
// PURPOSE
//  Memory stage plus MEM/WB pipeline register, directly downstream of the EX/MEM register.
//  Runs one load/store per instruction against a multi-cycle data memory (req/done handshake).
//  Drives EXMEM_stall back to EX/MEM while an access is outstanding.
//  Registers the write-back data, destination and halt state for the WB stage.
// PARAMETERS
//  TIMEOUT  15  max cycles spent in WAIT before an access is abandoned; legal range 1..255
// PORTS
//  clk              in   1   single clock, rising edge
//  rst              in   1   asynchronous, active-high reset
//  enable           in   1   EX/MEM memory enable: instruction is a load or store
//  wr               in   1   EX/MEM store when 1, load when 0 (valid only with enable)
//  ALU_Out          in   16  EX/MEM ALU result; doubles as the memory address
//  MEM_data_in      in   16  EX/MEM store data
//  Mux_MtoReg       in   1   1 = write back load data, 0 = write back ALU_Out
//  regWrite_enable  in   1   EX/MEM register-write enable
//  writeRegSel      in   3   EX/MEM destination register
//  createdump       in   1   EX/MEM halt/dump request
//  mem_req          out  1   one-cycle access request to memory
//  mem_wr           out  1   store qualifier for mem_req
//  mem_addr         out  16  = ALU_Out (combinational)
//  mem_wdata        out  16  = MEM_data_in (combinational)
//  mem_rdata        in   16  load data; valid only in the cycle mem_done is high
//  mem_done         in   1   access complete; may rise in the same cycle as mem_req (hit)
//  EXMEM_stall      out  1   holds EX/MEM (and everything upstream) this cycle
//  wb_data          out  16  registered write-back value
//  wb_regsel        out  3   registered destination register
//  wb_regwen        out  1   registered write enable; 0 = bubble
//  wb_halt          out  1   sticky halt flag for WB/testbench
//  mem_err          out  1   sticky timeout flag
// BEHAVIOUR
//  FSM states: IDLE, WAIT. Wait counter is 8 bits.
//  IDLE:
//   - mem_req = enable; mem_wr = enable & wr.
//   - enable & mem_done: access completes this cycle, no stall, FSM stays in IDLE.
//   - enable & ~mem_done: EXMEM_stall=1; next state WAIT; counter <= 1.
//   - ~enable: no request, no stall.
//  WAIT:
//   - mem_req=0 (no re-issue); EXMEM_stall = ~mem_done & ~timeout.
//   - mem_done: access completes; next state IDLE.
//   - Otherwise, if counter==TIMEOUT: set mem_err; treat as complete with wb_regwen=0; next state IDLE.
//   - Otherwise: counter increments.
//  Inputs held by EX/MEM during a stall are stable; the block does not latch them.
//  MEM/WB register, clocked every cycle:
//   - EXMEM_stall=1: wb_regwen<=0 (bubble); wb_data and wb_regsel hold.
//   - EXMEM_stall=0:
//     - wb_regwen <= regWrite_enable, forced to 0 on a timeout completion.
//     - wb_regsel <= writeRegSel.
//     - wb_data <= (enable & ~wr & Mux_MtoReg) ? mem_rdata : ALU_Out.
//  Load latency: a hit is 1 cycle to wb_*. A miss done in WAIT cycle N is visible at wb_* on the following edge.
//  wb_halt is set when createdump=1 and EXMEM_stall=0; it is never cleared except by rst.
//  mem_err is cleared only by rst.
//  Simultaneous mem_done and timeout in WAIT: mem_done wins and mem_err stays 0.
//  A store never writes the register file unless upstream sets regWrite_enable.
//  Reset (async, any state, including mid-WAIT):
//   - state=IDLE, counter=0.
//   - wb_data=0, wb_regsel=0, wb_regwen=0, wb_halt=0, mem_err=0.
//   - mem_req and EXMEM_stall are 0 while rst is high.
//   - A memory response arriving after reset is ignored (it lands in IDLE with enable=0).
// TESTING
//  Load hit: enable=1,wr=0,Mux_MtoReg=1,ALU_Out=0x0040,mem_done same cycle,rdata=0xBEEF,sel=3 -> next edge wb_data=0xBEEF,wb_regsel=3,wb_regwen=1,no stall.
//  Load miss: mem_done 3 cycles after req, rdata=0x1234 -> EXMEM_stall high 3 cycles, wb_regwen=0 during them, then wb_data=0x1234,wb_regwen=1; mem_req pulsed exactly once.
//  Store: enable=1,wr=1,ALU_Out=0x0010,MEM_data_in=0xA5A5,regWrite_enable=0, done 2 cycles later -> mem_wr=1 with req, mem_addr=0x0010, mem_wdata=0xA5A5, wb_regwen stays 0.
//  Timeout: TIMEOUT=4, mem_done never asserted -> stall for 4 cycles, mem_err=1 and sticky, wb_regwen=0, FSM back in IDLE, next instruction proceeds.
//  Reset mid-WAIT: assert rst in cycle 2 of a miss -> all outputs 0 immediately; a late mem_done after rst produces no wb_regwen.
//  Halt: createdump=1 during a non-memory op -> wb_halt=1 next edge and stays 1; createdump during a stalled load sets wb_halt only on the completion edge.

Source files
------------

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory-access stage plus MEM/WB pipeline register.
// Issues one load/store per instruction to a multi-cycle memory using a
// req/done handshake. It stalls EX/MEM while the access is outstanding and
// abandons the access after TIMEOUT cycles in WAIT.
module mem_wb_stage #(
    parameter int unsigned TIMEOUT = 15   // legal range 1..255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        wr,
    input  logic [15:0] ALU_Out,
    input  logic [15:0] MEM_data_in,
    input  logic        Mux_MtoReg,
    input  logic        regWrite_enable,
    input  logic [2:0]  writeRegSel,
    input  logic        createdump,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_done,
    output logic        EXMEM_stall,
    output logic [15:0] wb_data,
    output logic [2:0]  wb_regsel,
    output logic        wb_regwen,
    output logic        wb_halt,
    output logic        mem_err
);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t     state;
    logic [7:0] cnt;
    logic       timeout_hit;
    logic       load_sel;

    localparam logic [7:0] TMO = TIMEOUT[7:0];

    // EX/MEM holds these stable during a stall, so they pass straight through
    assign mem_addr  = ALU_Out;
    assign mem_wdata = MEM_data_in;

    // A response that arrives in the same cycle as the limit takes priority
    assign timeout_hit = (state == WAIT) && !mem_done && (cnt == TMO);
    assign load_sel    = enable && !wr && Mux_MtoReg;

    // Request and stall decode; forced quiet while reset is asserted
    always_comb begin
        mem_req     = 1'b0;
        mem_wr      = 1'b0;
        EXMEM_stall = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    mem_req     = enable;
                    mem_wr      = enable & wr;
                    EXMEM_stall = enable & ~mem_done;
                end
                WAIT: begin
                    EXMEM_stall = ~mem_done & ~timeout_hit;
                end
                default: ;
            endcase
        end
    end

    // Access FSM with wait counter and sticky timeout flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 8'd0;
            mem_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable && !mem_done) begin
                        state <= WAIT;
                        cnt   <= 8'd1;
                    end
                end
                WAIT: begin
                    if (mem_done) begin
                        state <= IDLE;
                        cnt   <= 8'd0;
                    end else if (cnt == TMO) begin
                        state   <= IDLE;
                        cnt     <= 8'd0;
                        mem_err <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 8'd0;
                end
            endcase
        end
    end

    // MEM/WB register: a stall inserts a bubble and holds data and destination
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_data   <= 16'd0;
            wb_regsel <= 3'd0;
            wb_regwen <= 1'b0;
        end else if (EXMEM_stall) begin
            wb_regwen <= 1'b0;
        end else begin
            wb_regwen <= regWrite_enable & ~timeout_hit;
            wb_regsel <= writeRegSel;
            wb_data   <= load_sel ? mem_rdata : ALU_Out;
        end
    end

    // Halt is latched only when the instruction carrying it retires
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wb_halt <= 1'b0;
        else if (createdump && !EXMEM_stall)
            wb_halt <= 1'b1;
    end

endmodule
